// File: rtl/dc_pred_ctrl.sv
// AV1 intra DC prediction sequencer: sums above/left neighbours, derives DC, emits raster 4x4 tiles.
// Optional macro DC_PRED_CTRL_PERF_EN adds perf_blocks / perf_stall counter outputs.
module dc_pred_ctrl #(
  parameter int SAMPLE_W = 10,
  parameter int SUM_W    = SAMPLE_W + 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_log2w,
  input  logic [2:0]          cmd_log2h,
  input  logic                cmd_have_above,
  input  logic                cmd_have_left,
  input  logic                nb_valid,
  output logic                nb_ready,
  input  logic [SAMPLE_W-1:0] nb_data,
  output logic                tile_valid,
  input  logic                tile_ready,
  output logic [3:0]          tile_x,
  output logic [3:0]          tile_y,
  output logic [SAMPLE_W-1:0] tile_dc,
  output logic                tile_last,
`ifdef DC_PRED_CTRL_PERF_EN
  output logic [15:0]         perf_blocks,
  output logic [15:0]         perf_stall,
`endif
  output logic                busy
);
  localparam int CNT_W = $clog2(SUM_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD_ABOVE, S_LOAD_LEFT, S_DIVIDE, S_EMIT} state_t;

  state_t              state_q;
  logic [2:0]          log2w_q, log2h_q;
  logic                have_above_q, have_left_q;
  logic [SUM_W-1:0]    sum_q, quo_q;
  logic [7:0]          rem_q;
  logic [6:0]          cnt_q;
  logic [CNT_W-1:0]    div_cnt_q;
  logic [3:0]          tile_x_q, tile_y_q;
  logic [SAMPLE_W-1:0] tile_dc_q;
  logic                tile_last_q;

  function automatic logic [2:0] clamp_log2(input logic [2:0] v);
    if (v < 3'd2) return 3'd2;
    if (v > 3'd6) return 3'd6;
    return v;
  endfunction

  logic [6:0]          w_len, h_len;
  logic [7:0]          wh_sum;
  logic [3:0]          wt_last, ht_last;
  logic [SUM_W-1:0]    sum_add;
  logic [SUM_W:0]      sum_ext;
  logic                nonsq_both;

  assign w_len      = 7'd1 << log2w_q;
  assign h_len      = 7'd1 << log2h_q;
  assign wh_sum     = {1'b0, w_len} + {1'b0, h_len};
  assign wt_last    = 4'((w_len >> 2) - 7'd1);
  assign ht_last    = 4'((h_len >> 2) - 7'd1);
  assign sum_add    = sum_q + SUM_W'(nb_data);
  assign sum_ext    = {1'b0, sum_q};
  assign nonsq_both = have_above_q && have_left_q && (log2w_q != log2h_q);

  // Restoring divider step; the first iteration seeds itself from the rounded sum.
  logic [SUM_W-1:0] div_num, quo_d;
  logic [7:0]       rem_src, rem_d;
  logic [8:0]       div_trial;
  logic             div_ge;
  always_comb begin
    div_num   = (div_cnt_q == '0) ? sum_q + SUM_W'(wh_sum >> 1) : quo_q;
    rem_src   = (div_cnt_q == '0) ? 8'd0 : rem_q;
    div_trial = {rem_src, div_num[SUM_W-1]};
    div_ge    = div_trial >= {1'b0, wh_sum};
    rem_d     = div_ge ? 8'(div_trial - {1'b0, wh_sum}) : div_trial[7:0];
    quo_d     = {div_num[SUM_W-2:0], div_ge};
  end

  logic [SAMPLE_W-1:0] dc_one;
  always_comb begin
    dc_one = '0;
    unique case ({have_above_q, have_left_q})
      2'b11:   dc_one = SAMPLE_W'((sum_ext + (SUM_W+1)'(w_len)) >> (log2w_q + 3'd1));
      2'b10:   dc_one = SAMPLE_W'((sum_ext + (SUM_W+1)'(w_len >> 1)) >> log2w_q);
      2'b01:   dc_one = SAMPLE_W'((sum_ext + (SUM_W+1)'(h_len >> 1)) >> log2h_q);
      default: dc_one[SAMPLE_W-1] = 1'b1;
    endcase
  end

  logic [3:0] nx_d, ny_d;
  logic       nlast_d;
  always_comb begin
    if (tile_x_q == wt_last) begin
      nx_d = 4'd0;
      ny_d = tile_y_q + 4'd1;
    end else begin
      nx_d = tile_x_q + 4'd1;
      ny_d = tile_y_q;
    end
    nlast_d = (nx_d == wt_last) && (ny_d == ht_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      log2w_q      <= 3'd2;
      log2h_q      <= 3'd2;
      have_above_q <= 1'b0;
      have_left_q  <= 1'b0;
      sum_q        <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      div_cnt_q    <= '0;
      tile_x_q     <= '0;
      tile_y_q     <= '0;
      tile_dc_q    <= '0;
      tile_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: if (cmd_valid) begin
          log2w_q      <= clamp_log2(cmd_log2w);
          log2h_q      <= clamp_log2(cmd_log2h);
          have_above_q <= cmd_have_above;
          have_left_q  <= cmd_have_left;
          sum_q        <= '0;
          cnt_q        <= '0;
          div_cnt_q    <= '0;
          if (cmd_have_above)     state_q <= S_LOAD_ABOVE;
          else if (cmd_have_left) state_q <= S_LOAD_LEFT;
          else                    state_q <= S_DIVIDE;
        end
        S_LOAD_ABOVE: if (nb_valid) begin
          sum_q <= sum_add;
          if (cnt_q == w_len - 7'd1) begin
            cnt_q   <= '0;
            state_q <= have_left_q ? S_LOAD_LEFT : S_DIVIDE;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_LOAD_LEFT: if (nb_valid) begin
          sum_q <= sum_add;
          if (cnt_q == h_len - 7'd1) begin
            cnt_q   <= '0;
            state_q <= S_DIVIDE;
          end else begin
            cnt_q <= cnt_q + 7'd1;
          end
        end
        S_DIVIDE: begin
          if (nonsq_both && div_cnt_q != CNT_W'(SUM_W - 1)) begin
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            div_cnt_q <= div_cnt_q + 1'b1;
          end else begin
            tile_dc_q   <= nonsq_both ? quo_d[SAMPLE_W-1:0] : dc_one;
            div_cnt_q   <= '0;
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            tile_last_q <= (log2w_q == 3'd2) && (log2h_q == 3'd2);
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: if (tile_ready) begin
          if (tile_last_q) begin
            tile_x_q    <= '0;
            tile_y_q    <= '0;
            tile_last_q <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            tile_x_q    <= nx_d;
            tile_y_q    <= ny_d;
            tile_last_q <= nlast_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign nb_ready   = (state_q == S_LOAD_ABOVE) || (state_q == S_LOAD_LEFT);
  assign tile_valid = (state_q == S_EMIT);
  assign busy       = (state_q != S_IDLE);
  assign tile_x     = tile_x_q;
  assign tile_y     = tile_y_q;
  assign tile_dc    = tile_dc_q;
  assign tile_last  = tile_last_q;

`ifdef DC_PRED_CTRL_PERF_EN
  logic [15:0] perf_blocks_q, perf_stall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_blocks_q <= '0;
      perf_stall_q  <= '0;
    end else if (state_q == S_EMIT) begin
      if (tile_ready && tile_last_q) perf_blocks_q <= perf_blocks_q + 16'd1;
      if (!tile_ready && perf_stall_q != 16'hFFFF) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end
  assign perf_blocks = perf_blocks_q;
  assign perf_stall  = perf_stall_q;
`endif
endmodule

// File: tb/tb_dc_pred_ctrl.sv
// Bench for dc_pred_ctrl: directed blocks plus random blocks scored against an arithmetic DC model.
module tb_dc_pred_ctrl;
  localparam int SW   = 10;
  localparam int SUMW = SW + 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_log2w = 3'd0, cmd_log2h = 3'd0;
  logic          cmd_have_above = 1'b0, cmd_have_left = 1'b0;
  logic          nb_valid = 1'b0;
  logic          nb_ready;
  logic [SW-1:0] nb_data = '0;
  logic          tile_valid;
  logic          tile_ready = 1'b0;
  logic [3:0]    tile_x, tile_y;
  logic [SW-1:0] tile_dc;
  logic          tile_last, busy;
`ifdef DC_PRED_CTRL_PERF_EN
  logic [15:0]   perf_blocks, perf_stall;
`endif

  dc_pred_ctrl #(.SAMPLE_W(SW), .SUM_W(SUMW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_log2w(cmd_log2w), .cmd_log2h(cmd_log2h),
    .cmd_have_above(cmd_have_above), .cmd_have_left(cmd_have_left),
    .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_data(nb_data),
    .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_x(tile_x), .tile_y(tile_y), .tile_dc(tile_dc), .tile_last(tile_last),
`ifdef DC_PRED_CTRL_PERF_EN
    .perf_blocks(perf_blocks), .perf_stall(perf_stall),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cyc = 0, nbr_cnt = 0, blocks_done = 0, stalls = 0;
  int above_q[$], left_q[$];
  bit tog;

  always @(posedge clk) begin
    cyc++;
    if (nb_ready === 1'b1) nbr_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampl(input int v);
    return (v < 2) ? 2 : ((v > 6) ? 6 : v);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_nb_ready"}, nb_ready, 0);
    check({tag, "_tile_valid"}, tile_valid, 0);
    check({tag, "_tile_x"}, tile_x, 0);
    check({tag, "_tile_y"}, tile_y, 0);
    check({tag, "_tile_dc"}, tile_dc, 0);
    check({tag, "_tile_last"}, tile_last, 0);
    check({tag, "_busy"}, busy, 0);
`ifdef DC_PRED_CTRL_PERF_EN
    check({tag, "_perf_blocks"}, perf_blocks, 0);
    check({tag, "_perf_stall"}, perf_stall, 0);
`endif
  endtask

  task automatic feed(input bit use_above, inout int t_last);
    int q[$];
    if (use_above) q = above_q;
    else           q = left_q;
    foreach (q[i]) begin
      if ($urandom_range(3) == 0) begin
        nb_valid = 1'b0;
        nb_data  = SW'($urandom);
        @(negedge clk);
      end
      for (int k = 0; k < 64 && nb_ready !== 1'b1; k++) @(negedge clk);
      check("nb_ready", nb_ready, 1);
      nb_valid = 1'b1;
      nb_data  = SW'(q[i]);
      t_last   = cyc;
      @(negedge clk);
      nb_valid = 1'b0;
    end
  endtask

  // Model: DC is the rounded mean of the available neighbours, mid-grey when none exist.
  task automatic run_block(input int lw_raw, input int lh_raw, input bit ha, input bit hl,
                           input int mode);
    int lw, lh, w, h, n, sum, exp_dc, lat, t0, nb0;
    bit rdy, done;
    lw = clampl(lw_raw);
    lh = clampl(lh_raw);
    w  = 1 << lw;
    h  = 1 << lh;
    sum = 0;
    n   = 0;
    if (ha) begin foreach (above_q[i]) sum += above_q[i]; n += w; end
    if (hl) begin foreach (left_q[i]) sum += left_q[i]; n += h; end
    exp_dc = (n == 0) ? (1 << (SW - 1)) : (sum + n / 2) / n;

    for (int k = 0; k < 64 && cmd_ready !== 1'b1; k++) @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid      = 1'b1;
    cmd_log2w      = 3'(lw_raw);
    cmd_log2h      = 3'(lh_raw);
    cmd_have_above = ha;
    cmd_have_left  = hl;
    t0  = cyc;
    nb0 = nbr_cnt;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_cmd", busy, 1);
    check("cmd_ready_busy", cmd_ready, 0);

    if (ha) feed(1'b1, t0);
    if (hl) feed(1'b0, t0);

    lat = (ha && hl && lw != lh) ? SUMW + 1 : 2;
    for (int k = 0; k < 100 && tile_valid !== 1'b1; k++) @(negedge clk);
    check("dc_latency", cyc - t0, lat);
    if (!ha && !hl) check("nb_ready_pulses", nbr_cnt - nb0, 0);

    tog = 1'b1;
    for (int ty = 0; ty < h / 4; ty++) begin
      for (int tx = 0; tx < w / 4; tx++) begin
        done = 1'b0;
        while (!done) begin
          check("tile_valid", tile_valid, 1);
          check("tile_x", tile_x, tx);
          check("tile_y", tile_y, ty);
          check("tile_dc", tile_dc, exp_dc);
          check("tile_last", tile_last, (tx == w / 4 - 1 && ty == h / 4 - 1) ? 1 : 0);
          case (mode)
            0:       rdy = 1'b1;
            1:       begin tog = !tog; rdy = tog; end
            default: rdy = 1'($urandom_range(1));
          endcase
          tile_ready = rdy;
          if (!rdy) stalls++;
          @(negedge clk);
          done = rdy;
        end
      end
    end
    tile_ready = 1'b0;
    blocks_done++;
    check("end_tile_valid", tile_valid, 0);
    check("end_cmd_ready", cmd_ready, 1);
    check("end_busy", busy, 0);
`ifdef DC_PRED_CTRL_PERF_EN
    check("perf_blocks", perf_blocks, blocks_done);
    check("perf_stall", perf_stall, stalls);
`endif
    $display("block %0dx%0d above=%0d left=%0d mode=%0d dc=%0d", w, h, ha, hl, mode, exp_dc);
  endtask

  initial begin
    int lw, lh;
    bit ha, hl;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_release");

    // 4x4 left only
    left_q = {12, 13, 5, 3};
    run_block(2, 2, 1'b0, 1'b1, 0);

    // 4x4 neither edge
    run_block(2, 2, 1'b0, 1'b0, 0);

    // 8x4 both edges, non-square divide
    above_q = {};
    left_q  = {};
    repeat (8) above_q.push_back(100);
    repeat (4) left_q.push_back(40);
    run_block(3, 2, 1'b1, 1'b1, 0);

    // 16x16 above only at full scale with toggled backpressure
    above_q = {};
    repeat (16) above_q.push_back(1023);
    run_block(4, 4, 1'b1, 1'b0, 1);

    // Reset in the middle of the left edge load
    for (int k = 0; k < 64 && cmd_ready !== 1'b1; k++) @(negedge clk);
    cmd_valid = 1'b1; cmd_log2w = 3'd2; cmd_log2h = 3'd3;
    cmd_have_above = 1'b0; cmd_have_left = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 64 && nb_ready !== 1'b1; k++) @(negedge clk);
      nb_valid = 1'b1;
      nb_data  = 10'd700;
      @(negedge clk);
      nb_valid = 1'b0;
    end
    check("mid_load_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    blocks_done = 0;
    stalls = 0;
    @(negedge clk);
    above_q = {4, 4, 4, 4};
    run_block(2, 2, 1'b1, 1'b0, 0);

    // Random blocks, including out-of-range sizes and random backpressure
    repeat (25) begin
      lw = $urandom_range(7);
      lh = $urandom_range(7);
      ha = 1'($urandom_range(1));
      hl = 1'($urandom_range(1));
      above_q = {};
      left_q  = {};
      repeat (1 << clampl(lw)) above_q.push_back(int'($urandom_range(1023)));
      repeat (1 << clampl(lh)) left_q.push_back(int'($urandom_range(1023)));
      run_block(lw, lh, ha, hl, int'($urandom_range(2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dc_pred_ctrl.md
Name: dc_pred_ctrl

Overview:
Sequencer for AV1 intra DC prediction of one transform block. Accepts a block descriptor, consumes the available above/left neighbour samples as a stream, and accumulates their sum. Derives the DC value by shift or by iterative division, then emits the block as raster-ordered 4x4 tiles with valid/ready. It sits between the neighbour fetch logic and the reconstruction adder; downstream replicates tile_dc across the 16 tile pixels.

Parameters:
SAMPLE_W, 10, sample bit depth.
SUM_W, SAMPLE_W+7, accumulator width (128 samples max).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  block descriptor valid
cmd_ready  out  1  high only in IDLE
cmd_log2w  in  3  log2 block width, 2..6
cmd_log2h  in  3  log2 block height, 2..6
cmd_have_above  in  1  above row available
cmd_have_left  in  1  left column available
nb_valid  in  1  neighbour sample valid
nb_ready  out  1  high only in LOAD_ABOVE/LOAD_LEFT
nb_data  in  SAMPLE_W  neighbour sample
tile_valid  out  1  output tile valid
tile_ready  in  1  downstream accepts tile
tile_x  out  4  tile column index
tile_y  out  4  tile row index
tile_dc  out  SAMPLE_W  DC value for all 16 pixels
tile_last  out  1  final tile of block
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, cmd_ready=1, nb_ready=0, tile_valid=0, tile_x=tile_y=0, tile_dc=0, tile_last=0, busy=0, accumulator and counters cleared. Asserting rst_n low mid-block aborts it immediately; no partial tile survives.
- IDLE: on cmd_valid&cmd_ready, latch the descriptor and clear the accumulator and sample count. Next state is LOAD_ABOVE if have_above, else LOAD_LEFT if have_left, else DIVIDE.
- LOAD_ABOVE: each nb_valid&nb_ready adds nb_data and increments the count. After w=1<<log2w samples, go to LOAD_LEFT if have_left, else DIVIDE. Stall with no change while nb_valid=0.
- LOAD_LEFT: same, for h samples, then DIVIDE.
- DIVIDE, both edges, square: dc=(sum+w)>>(log2w+1). One cycle.
- DIVIDE, both edges, non-square: dc=(sum+((w+h)>>1))/(w+h), floor. Computed with a restoring divider, one quotient bit per cycle, SUM_W cycles.
- DIVIDE, above only: dc=(sum+(w>>1))>>log2w. One cycle.
- DIVIDE, left only: dc=(sum+(h>>1))>>log2h. One cycle.
- DIVIDE, neither edge: dc=1<<(SAMPLE_W-1). One cycle.
- Result: dc is truncated to SAMPLE_W. It cannot exceed the max sample, so no clamp is needed.
- EMIT: tile_valid=1 with tile_x=tile_y=0 on the cycle after DIVIDE completes.
- EMIT advance: each tile_valid&tile_ready advances tile_x; wrap at (w>>2)-1 increments tile_y.
- EMIT end: tile_last=1 when tile_x=(w>>2)-1 and tile_y=(h>>2)-1. Acceptance of the last tile returns to IDLE with cmd_ready=1 on the next cycle.
- Backpressure: while tile_valid&!tile_ready, tile_x, tile_y, tile_dc and tile_last hold stable.
- Bubbles: no bubble between accepted tiles. A 4x4 block gives exactly one tile, with tile_last=1.
- Ignored inputs: cmd_valid is ignored outside IDLE; nb_valid is ignored outside the LOAD states.
- Illegal descriptors: cmd_log2w/log2h outside 2..6 are clamped into range at latch.

Optional Feature:
DC_PRED_CTRL_PERF_EN.
- Defined: adds output perf_blocks (16 bits, blocks completed, wraps at 0xFFFF) and output perf_stall (16 bits, saturating count of EMIT cycles with tile_valid&!tile_ready). Both reset to 0 on rst_n.
- Undefined: neither port nor counter exists. Functional behaviour is otherwise identical.

Test Plan:
- 4x4, left only, left=12,13,5,3 -> one tile (0,0), tile_dc=8, tile_last=1; cmd_ready high again after acceptance.
- 4x4, neither edge, SAMPLE_W=10 -> no nb_ready pulses; tile_dc=512 exactly 2 cycles after the command is accepted.
- 8x4, both edges, above=8x100, left=4x40 -> DIVIDE lasts SUM_W cycles; tile_dc=80; tiles (0,0),(1,0), last on (1,0).
- 16x16, above only, all samples 1023 -> tile_dc=1023; 16 tiles in raster order; tile_ready toggled 1/0 holds tile fields stable on low cycles.
- Reset mid-LOAD_LEFT, after 2 of 8 samples -> outputs at reset values; the next 4x4 above-only block with samples 4,4,4,4 gives tile_dc=4.
- With DC_PRED_CTRL_PERF_EN, 3 blocks back-to-back with 5 stall cycles -> perf_blocks=3, perf_stall=5.
